// File: rtl/dmem_mshr_arb_if.sv
// Request channels and memory bus of the data-memory MSHR arbiter.
// slave: the arbiter side; master: the requester/memory side.
interface dmem_mshr_arb_if #(
    parameter int NCH   = 3,
    parameter int NMSHR = 4,
    parameter int ID_W  = 4
);
    localparam int FW = $clog2(NMSHR) + 1;

    logic                except;
    logic [NCH-1:0]      req_valid;
    logic [NCH-1:0]      req_is_st;
    logic [NCH*16-1:0]   req_addr;
    logic [NCH*2-1:0]    req_size;
    logic [NCH*64-1:0]   req_data;
    logic [NCH*ID_W-1:0] req_id;
    logic [NCH-1:0]      req_ready;
    logic [3:0]          mem2proc_response;
    logic [63:0]         mem2proc_data;
    logic [3:0]          mem2proc_tag;
    logic [1:0]          Dmem_command;
    logic [15:0]         Dmem_addr;
    logic [1:0]          Dmem_size;
    logic [63:0]         Dmem_data;
    logic [NCH-1:0]      resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [63:0]         resp_data;
    logic [FW-1:0]       mshr_free;

    modport slave (
        input  except, req_valid, req_is_st, req_addr, req_size,
        input  req_data, req_id,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output req_ready, Dmem_command, Dmem_addr, Dmem_size,
        output Dmem_data, resp_valid, resp_id, resp_data, mshr_free
    );

    modport master (
        output except, req_valid, req_is_st, req_addr, req_size,
        output req_data, req_id,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  req_ready, Dmem_command, Dmem_addr, Dmem_size,
        input  Dmem_data, resp_valid, resp_id, resp_data, mshr_free
    );
endinterface

// File: rtl/dmem_mshr_arb.sv
// Data-memory arbiter: NCH channels -> one issue register -> 64-bit bus,
// with an NMSHR-entry load table matching memory tags back to channels.
// Ports: clock, reset (sync, active-low), io (dmem_mshr_arb_if.slave):
//   req_* / req_ready channel side, mem2proc_* / Dmem_* bus side,
//   resp_* load completion, mshr_free free-entry count, except squash.
module dmem_mshr_arb #(
    parameter int NCH     = 3,
    parameter int NMSHR   = 4,
    parameter int ID_W    = 4,
    parameter int RR_MODE = 1
) (
    input logic            clock,
    input logic            reset,
    dmem_mshr_arb_if.slave io
);
    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(NMSHR) + 1;
    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_PEND  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            iss_st_q, iss_st_d;
    logic [15:0]     iss_addr_q, iss_addr_d;
    logic [1:0]      iss_size_q, iss_size_d;
    logic [63:0]     iss_data_q, iss_data_d;
    logic [ID_W-1:0] iss_id_q, iss_id_d;
    logic [CW-1:0]   iss_ch_q, iss_ch_d;
    logic [CW-1:0]   rr_q, rr_d;

    logic [NMSHR-1:0] mv_q, mv_d;
    logic [NMSHR-1:0] msq_q, msq_d;
    logic [3:0]       mtag_q [NMSHR];
    logic [3:0]       mtag_d [NMSHR];
    logic [ID_W-1:0]  mid_q [NMSHR];
    logic [ID_W-1:0]  mid_d [NMSHR];
    logic [CW-1:0]    mch_q [NMSHR];
    logic [CW-1:0]    mch_d [NMSHR];

    logic [NCH-1:0]  rv_q, rv_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [FW-1:0]   free_q, free_d;

    logic             pend, accept, pend_ld, arb_en, ld_ok, gnt, found;
    logic [NCH-1:0]   elig, grant;
    logic [2*NCH-1:0] dbl;
    logic [CW-1:0]    rr_sh, off, win;
    logic [CW:0]      sum;

    // Arbiter: rotate the eligible mask so the search starts at rr_sh.
    always_comb begin
        pend    = (state_q == S_PEND);
        accept  = pend && (io.mem2proc_response != 4'd0);
        pend_ld = pend && !iss_st_q;
        arb_en  = !pend || accept;
        // The load sitting in issue already owns one free entry.
        ld_ok   = !io.except && (free_q > FW'(pend_ld));
        elig    = io.req_valid & (io.req_is_st | {NCH{ld_ok}});
        rr_sh   = (RR_MODE != 0) ? rr_q : '0;
        dbl     = {elig, elig} >> rr_sh;
        gnt     = 1'b0;
        off     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt && dbl[k]) begin
                gnt = 1'b1;
                off = CW'(k);
            end
        end
        sum = {1'b0, rr_sh} + {1'b0, off};
        if (sum >= NCH_L) sum = sum - NCH_L;
        win   = sum[CW-1:0];
        gnt   = gnt && arb_en && reset;
        grant = '0;
        for (int c = 0; c < NCH; c++) begin
            grant[c] = gnt && (win == CW'(c));
        end
    end

    assign io.req_ready = grant;

    always_comb begin
        state_d    = state_q;
        iss_st_d   = iss_st_q;
        iss_addr_d = iss_addr_q;
        iss_size_d = iss_size_q;
        iss_data_d = iss_data_q;
        iss_id_d   = iss_id_q;
        iss_ch_d   = iss_ch_q;
        rr_d       = rr_q;
        if (accept || (pend_ld && io.except)) state_d = S_EMPTY;
        for (int c = 0; c < NCH; c++) begin
            if (grant[c]) begin
                state_d    = S_PEND;
                iss_st_d   = io.req_is_st[c];
                iss_addr_d = io.req_addr[c*16 +: 16];
                iss_size_d = io.req_size[c*2 +: 2];
                iss_data_d = io.req_data[c*64 +: 64];
                iss_id_d   = io.req_id[c*ID_W +: ID_W];
                iss_ch_d   = CW'(c);
            end
        end
        if (gnt && RR_MODE != 0) begin
            rr_d = (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
        end
    end

    always_comb begin
        mv_d    = mv_q;
        msq_d   = msq_q;
        mtag_d  = mtag_q;
        mid_d   = mid_q;
        mch_d   = mch_q;
        rv_d    = '0;
        rid_d   = '0;
        rdata_d = '0;
        found   = 1'b0;
        for (int i = 0; i < NMSHR; i++) begin
            if (mv_q[i] && io.mem2proc_tag != 4'd0
                && mtag_q[i] == io.mem2proc_tag) begin
                mv_d[i] = 1'b0;
                // A squash in the same cycle also silences the return.
                if (!msq_q[i] && !io.except) begin
                    rv_d    = NCH'(1) << mch_q[i];
                    rid_d   = mid_q[i];
                    rdata_d = io.mem2proc_data;
                end
            end
        end
        if (io.except) msq_d = msq_q | mv_q;
        // Allocation looks at mv_q so a slot freed now stays free a cycle.
        if (accept && !iss_st_q) begin
            for (int i = 0; i < NMSHR; i++) begin
                if (!found && !mv_q[i]) begin
                    found     = 1'b1;
                    mv_d[i]   = 1'b1;
                    msq_d[i]  = io.except;
                    mtag_d[i] = io.mem2proc_response;
                    mid_d[i]  = iss_id_q;
                    mch_d[i]  = iss_ch_q;
                end
            end
        end
        free_d = '0;
        for (int i = 0; i < NMSHR; i++) begin
            if (!mv_d[i]) free_d = free_d + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            iss_st_q   <= 1'b0;
            iss_addr_q <= '0;
            iss_size_q <= '0;
            iss_data_q <= '0;
            iss_id_q   <= '0;
            iss_ch_q   <= '0;
            rr_q       <= '0;
            mv_q       <= '0;
            msq_q      <= '0;
            for (int i = 0; i < NMSHR; i++) begin
                mtag_q[i] <= '0;
                mid_q[i]  <= '0;
                mch_q[i]  <= '0;
            end
            rv_q    <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            free_q  <= FW'(NMSHR);
        end else begin
            state_q    <= state_d;
            iss_st_q   <= iss_st_d;
            iss_addr_q <= iss_addr_d;
            iss_size_q <= iss_size_d;
            iss_data_q <= iss_data_d;
            iss_id_q   <= iss_id_d;
            iss_ch_q   <= iss_ch_d;
            rr_q       <= rr_d;
            mv_q       <= mv_d;
            msq_q      <= msq_d;
            mtag_q     <= mtag_d;
            mid_q      <= mid_d;
            mch_q      <= mch_d;
            rv_q       <= rv_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            free_q     <= free_d;
        end
    end

    assign io.Dmem_command = !pend ? 2'd0 : (iss_st_q ? 2'd2 : 2'd1);
    assign io.Dmem_addr    = pend ? iss_addr_q : '0;
    assign io.Dmem_size    = pend ? iss_size_q : '0;
    assign io.Dmem_data    = pend ? iss_data_q : '0;
    assign io.resp_valid   = rv_q;
    assign io.resp_id      = rid_q;
    assign io.resp_data    = rdata_q;
    assign io.mshr_free    = free_q;
endmodule

// File: tb/tb_dmem_mshr_arb.sv
// Testbench for dmem_mshr_arb: arbitration vector table, directed
// load/squash/reset sequences and a randomized run against a queue model.
module tb_dmem_mshr_arb;
    localparam int NCH   = 3;
    localparam int NMSHR = 4;
    localparam int ID_W  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_mshr_arb_if #(.NCH(NCH), .NMSHR(NMSHR), .ID_W(ID_W)) rr_io ();
    dmem_mshr_arb_if #(.NCH(NCH), .NMSHR(NMSHR), .ID_W(ID_W)) fp_io ();

    dmem_mshr_arb #(.NCH(NCH), .NMSHR(NMSHR), .ID_W(ID_W), .RR_MODE(1)) u_rr (
        .clock(clock), .reset(reset), .io(rr_io.slave)
    );
    dmem_mshr_arb #(.NCH(NCH), .NMSHR(NMSHR), .ID_W(ID_W), .RR_MODE(0)) u_fp (
        .clock(clock), .reset(reset), .io(fp_io.slave)
    );

    assign fp_io.except            = rr_io.except;
    assign fp_io.req_valid         = rr_io.req_valid;
    assign fp_io.req_is_st         = rr_io.req_is_st;
    assign fp_io.req_addr          = rr_io.req_addr;
    assign fp_io.req_size          = rr_io.req_size;
    assign fp_io.req_data          = rr_io.req_data;
    assign fp_io.req_id            = rr_io.req_id;
    assign fp_io.mem2proc_response = rr_io.mem2proc_response;
    assign fp_io.mem2proc_data     = rr_io.mem2proc_data;
    assign fp_io.mem2proc_tag      = rr_io.mem2proc_tag;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        rr_io.except            = 1'b0;
        rr_io.req_valid         = '0;
        rr_io.req_is_st         = '0;
        rr_io.req_addr          = '0;
        rr_io.req_size          = '0;
        rr_io.req_data          = '0;
        rr_io.req_id            = '0;
        rr_io.mem2proc_response = '0;
        rr_io.mem2proc_data     = '0;
        rr_io.mem2proc_tag      = '0;
    endtask

    task automatic set_req(input int c, input logic st, input logic [15:0] a,
                           input logic [1:0] sz, input logic [ID_W-1:0] id,
                           input logic [63:0] d);
        rr_io.req_valid[c]           = 1'b1;
        rr_io.req_is_st[c]           = st;
        rr_io.req_addr[c*16 +: 16]   = a;
        rr_io.req_size[c*2 +: 2]     = sz;
        rr_io.req_data[c*64 +: 64]   = d;
        rr_io.req_id[c*ID_W +: ID_W] = id;
    endtask

    // Arbitration table: all channels stream stores at 0x1000+ch.
    typedef struct {
        logic [2:0]  vld;
        logic [3:0]  rsp;
        logic [2:0]  rdy_rr;
        logic [2:0]  rdy_fp;
        logic [1:0]  cmd;
        logic [15:0] addr;
    } vec_t;
    vec_t tv [11];

    // Behavioural model for the random phase.
    typedef struct {
        logic [3:0]      tag;
        logic [ID_W-1:0] id;
        int              ch;
        bit              sq;
    } ent_t;
    ent_t q [$];
    bit              m_iv, m_ist;
    logic [15:0]     m_ia;
    logic [1:0]      m_isz;
    logic [63:0]     m_idat;
    logic [ID_W-1:0] m_iid;
    int              m_ich, m_rr;
    logic [2:0]      e_rv;
    logic [ID_W-1:0] e_rid;
    logic [63:0]     e_rd;
    logic [2:0]      n_rv;
    logic [ID_W-1:0] n_rid;
    logic [63:0]     n_rd;
    logic [NCH-1:0]  v, st;
    logic [15:0]     a   [NCH];
    logic [1:0]      sz  [NCH];
    logic [63:0]     d   [NCH];
    logic [ID_W-1:0] id  [NCH];
    logic [3:0]      tg, rsp;
    logic [63:0]     tdat;
    logic [2:0]      e_rdy;
    bit              exc, acc, arb, ldok;
    int              win, cc, r, hit;

    function automatic logic [3:0] unused_tag(input logic [3:0] excl);
        logic [3:0] t;
        bit clash;
        for (int n = 0; n < 64; n++) begin
            t = 4'($urandom_range(1, 15));
            clash = (t == excl);
            foreach (q[j]) if (q[j].tag == t) clash = 1'b1;
            if (!clash) return t;
        end
        return 4'd0;
    endfunction

    initial begin
        tv[0]  = '{3'b111, 4'd0, 3'b001, 3'b001, 2'd0, 16'h0000};
        tv[1]  = '{3'b111, 4'd1, 3'b010, 3'b001, 2'd2, 16'h1000};
        tv[2]  = '{3'b111, 4'd1, 3'b100, 3'b001, 2'd2, 16'h1001};
        tv[3]  = '{3'b111, 4'd1, 3'b001, 3'b001, 2'd2, 16'h1002};
        tv[4]  = '{3'b111, 4'd0, 3'b000, 3'b000, 2'd2, 16'h1000};
        tv[5]  = '{3'b111, 4'd0, 3'b000, 3'b000, 2'd2, 16'h1000};
        tv[6]  = '{3'b111, 4'd0, 3'b000, 3'b000, 2'd2, 16'h1000};
        tv[7]  = '{3'b111, 4'd1, 3'b010, 3'b001, 2'd2, 16'h1000};
        tv[8]  = '{3'b010, 4'd1, 3'b010, 3'b010, 2'd2, 16'h1001};
        tv[9]  = '{3'b000, 4'd1, 3'b000, 3'b000, 2'd2, 16'h1001};
        tv[10] = '{3'b000, 4'd0, 3'b000, 3'b000, 2'd0, 16'h0000};

        // Reset values, with requests asserted during reset.
        idle();
        reset = 1'b0;
        tick();
        tick();
        for (int c = 0; c < NCH; c++) set_req(c, 1'b1, 16'h1234, 2'd3, '0, 64'h1);
        #1;
        chk("rst ready", rr_io.req_ready, 0);
        chk("rst cmd", rr_io.Dmem_command, 0);
        chk("rst addr", rr_io.Dmem_addr, 0);
        chk("rst size", rr_io.Dmem_size, 0);
        chk("rst data", rr_io.Dmem_data, 0);
        chk("rst rv", rr_io.resp_valid, 0);
        chk("rst rid", rr_io.resp_id, 0);
        chk("rst rdata", rr_io.resp_data, 0);
        chk("rst free", rr_io.mshr_free, NMSHR);
        tick();
        reset = 1'b1;

        // Table: round-robin vs fixed priority, stall holds the bus.
        for (int i = 0; i < 11; i++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                if (tv[i].vld[c]) begin
                    set_req(c, 1'b1, 16'(16'h1000 + c), 2'd3, '0,
                            {48'hD000_0000_0000, 16'(16'h1000 + c)});
                end
            end
            rr_io.mem2proc_response = tv[i].rsp;
            #1;
            chk($sformatf("tv%0d rdy_rr", i), rr_io.req_ready, tv[i].rdy_rr);
            chk($sformatf("tv%0d rdy_fp", i), fp_io.req_ready, tv[i].rdy_fp);
            chk($sformatf("tv%0d cmd_rr", i), rr_io.Dmem_command, tv[i].cmd);
            chk($sformatf("tv%0d cmd_fp", i), fp_io.Dmem_command, tv[i].cmd);
            if (tv[i].cmd != 2'd0) begin
                chk($sformatf("tv%0d addr", i), rr_io.Dmem_addr, tv[i].addr);
                chk($sformatf("tv%0d size", i), rr_io.Dmem_size, 2'd3);
                chk($sformatf("tv%0d data", i), rr_io.Dmem_data,
                    {48'hD000_0000_0000, tv[i].addr});
            end
            tick();
        end

        // Single load ch2, tag returned four cycles after the bus cycle.
        idle();
        set_req(2, 1'b0, 16'h0100, 2'd3, 4'd5, '0);
        #1;
        chk("ld1 ready", rr_io.req_ready, 3'b100);
        tick();
        idle();
        rr_io.mem2proc_response = 4'd3;
        #1;
        chk("ld1 cmd", rr_io.Dmem_command, 1);
        chk("ld1 addr", rr_io.Dmem_addr, 16'h0100);
        tick();
        idle();
        #1;
        chk("ld1 free", rr_io.mshr_free, 3);
        tick();
        tick();
        tick();
        rr_io.mem2proc_tag  = 4'd3;
        rr_io.mem2proc_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("ld1 early rv", rr_io.resp_valid, 0);
        tick();
        idle();
        #1;
        chk("ld1 rv", rr_io.resp_valid, 3'b100);
        chk("ld1 rid", rr_io.resp_id, 5);
        chk("ld1 rdata", rr_io.resp_data, 64'hDEAD_BEEF_0000_0001);
        chk("ld1 free4", rr_io.mshr_free, 4);
        tick();

        // Fill the table with ch0 loads; fifth waits for a free entry.
        idle();
        set_req(0, 1'b0, 16'h0200, 2'd3, 4'd1, '0);
        #1;
        chk("full g0", rr_io.req_ready, 3'b001);
        tick();
        for (int k = 1; k <= 3; k++) begin
            idle();
            set_req(0, 1'b0, 16'(16'h0200 + k), 2'd3, ID_W'(k + 1), '0);
            rr_io.mem2proc_response = 4'(k);
            #1;
            chk($sformatf("full g%0d", k), rr_io.req_ready, 3'b001);
            tick();
        end
        idle();
        set_req(0, 1'b0, 16'h0204, 2'd3, 4'd5, '0);
        rr_io.mem2proc_response = 4'd4;
        #1;
        chk("full blk1", rr_io.req_ready, 0);
        tick();
        idle();
        set_req(0, 1'b0, 16'h0204, 2'd3, 4'd5, '0);
        rr_io.mem2proc_tag  = 4'd2;
        rr_io.mem2proc_data = 64'h22;
        #1;
        chk("full blk2", rr_io.req_ready, 0);
        chk("full free0", rr_io.mshr_free, 0);
        tick();
        idle();
        set_req(0, 1'b0, 16'h0204, 2'd3, 4'd5, '0);
        #1;
        chk("full regrant", rr_io.req_ready, 3'b001);
        chk("full free1", rr_io.mshr_free, 1);
        chk("full rv", rr_io.resp_valid, 3'b001);
        chk("full rid", rr_io.resp_id, 2);
        tick();
        idle();
        rr_io.mem2proc_response = 4'd5;
        #1;
        chk("full ld5 addr", rr_io.Dmem_addr, 16'h0204);
        tick();
        for (int t = 1; t <= 5; t++) begin
            if (t != 2) begin
                idle();
                rr_io.mem2proc_tag = 4'(t);
                tick();
            end
        end
        idle();
        #1;
        chk("full drain", rr_io.mshr_free, 4);

        // Except: two outstanding loads and one pending load.
        set_req(0, 1'b0, 16'h0300, 2'd3, 4'd1, '0);
        tick();
        idle();
        set_req(0, 1'b0, 16'h0301, 2'd3, 4'd2, '0);
        rr_io.mem2proc_response = 4'd6;
        tick();
        idle();
        set_req(0, 1'b0, 16'h0302, 2'd3, 4'd3, '0);
        rr_io.mem2proc_response = 4'd7;
        tick();
        idle();
        rr_io.except = 1'b1;
        #1;
        chk("exc pend ld", rr_io.Dmem_command, 1);
        tick();
        idle();
        rr_io.mem2proc_tag = 4'd6;
        #1;
        chk("exc dropped", rr_io.Dmem_command, 0);
        chk("exc free2", rr_io.mshr_free, 2);
        tick();
        idle();
        rr_io.mem2proc_tag = 4'd7;
        #1;
        chk("exc rv6", rr_io.resp_valid, 0);
        tick();
        idle();
        #1;
        chk("exc rv7", rr_io.resp_valid, 0);
        chk("exc free4", rr_io.mshr_free, 4);

        // Except while a store is pending: the store still completes.
        set_req(1, 1'b1, 16'h0400, 2'd3, '0, 64'h44);
        tick();
        idle();
        rr_io.except = 1'b1;
        #1;
        chk("exc st cmd", rr_io.Dmem_command, 2);
        tick();
        idle();
        rr_io.except = 1'b1;
        rr_io.mem2proc_response = 4'd1;
        set_req(0, 1'b0, 16'h0401, 2'd3, 4'd1, '0);
        #1;
        chk("exc st held", rr_io.Dmem_command, 2);
        chk("exc st addr", rr_io.Dmem_addr, 16'h0400);
        chk("exc no ld", rr_io.req_ready, 0);
        tick();
        idle();
        #1;
        chk("exc st done", rr_io.Dmem_command, 0);

        // Reset with a load outstanding and a store pending.
        set_req(2, 1'b0, 16'h0500, 2'd3, 4'd9, '0);
        #1;
        chk("rst2 grant", rr_io.req_ready, 3'b100);
        tick();
        idle();
        rr_io.mem2proc_response = 4'd8;
        set_req(0, 1'b1, 16'h0501, 2'd3, '0, 64'h55);
        #1;
        chk("rst2 bus", rr_io.Dmem_command, 1);
        chk("rst2 st grant", rr_io.req_ready, 3'b001);
        tick();
        idle();
        reset = 1'b0;
        set_req(0, 1'b1, 16'h0501, 2'd3, '0, 64'h55);
        #1;
        chk("rst2 ready", rr_io.req_ready, 0);
        tick();
        reset = 1'b1;
        idle();
        rr_io.mem2proc_tag  = 4'd8;
        rr_io.mem2proc_data = 64'h88;
        #1;
        chk("rst2 cmd", rr_io.Dmem_command, 0);
        chk("rst2 addr", rr_io.Dmem_addr, 0);
        chk("rst2 data", rr_io.Dmem_data, 0);
        chk("rst2 free", rr_io.mshr_free, 4);
        chk("rst2 rv0", rr_io.resp_valid, 0);
        tick();
        idle();
        #1;
        chk("rst2 late tag", rr_io.resp_valid, 0);
        chk("rst2 rid", rr_io.resp_id, 0);
        chk("rst2 rdata", rr_io.resp_data, 0);

        // Random run against the model, from a fresh reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        q.delete();
        m_iv = 0; m_ist = 0; m_ia = '0; m_isz = '0; m_idat = '0;
        m_iid = '0; m_ich = 0; m_rr = 0;
        e_rv = '0; e_rid = '0; e_rd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                v[c]  = ($urandom_range(0, 99) < 50);
                st[c] = 1'($urandom_range(0, 1));
                a[c]  = 16'($urandom);
                sz[c] = 2'($urandom);
                d[c]  = {$urandom, $urandom};
                id[c] = ID_W'($urandom);
                if (v[c]) set_req(c, st[c], a[c], sz[c], id[c], d[c]);
            end
            exc = ($urandom_range(0, 99) < 4);
            r   = $urandom_range(0, 99);
            tg  = 4'd0;
            if (q.size() > 0 && r < 30) tg = q[$urandom_range(0, q.size() - 1)].tag;
            else if (r < 38) tg = unused_tag(4'd0);
            tdat = {$urandom, $urandom};
            rsp = 4'd0;
            if (m_iv && $urandom_range(0, 99) < 60) rsp = unused_tag(tg);
            if (!m_iv && $urandom_range(0, 99) < 10) rsp = 4'($urandom_range(1, 15));
            rr_io.except            = exc;
            rr_io.mem2proc_tag      = tg;
            rr_io.mem2proc_data     = tdat;
            rr_io.mem2proc_response = rsp;

            acc  = m_iv && rsp != 4'd0;
            arb  = !m_iv || acc;
            ldok = !exc && ((NMSHR - q.size() - ((m_iv && !m_ist) ? 1 : 0)) > 0);
            win  = -1;
            if (arb) begin
                for (int k = 0; k < NCH; k++) begin
                    cc = (m_rr + k) % NCH;
                    if (win < 0 && v[cc] && (st[cc] || ldok)) win = cc;
                end
            end
            e_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
            #1;
            chk($sformatf("rnd%0d ready", cyc), rr_io.req_ready, e_rdy);
            chk($sformatf("rnd%0d cmd", cyc), rr_io.Dmem_command,
                !m_iv ? 2'd0 : (m_ist ? 2'd2 : 2'd1));
            if (m_iv) begin
                chk($sformatf("rnd%0d addr", cyc), rr_io.Dmem_addr, m_ia);
                chk($sformatf("rnd%0d size", cyc), rr_io.Dmem_size, m_isz);
                if (m_ist) chk($sformatf("rnd%0d data", cyc), rr_io.Dmem_data, m_idat);
            end
            chk($sformatf("rnd%0d rv", cyc), rr_io.resp_valid, e_rv);
            if (e_rv != 3'b000) begin
                chk($sformatf("rnd%0d rid", cyc), rr_io.resp_id, e_rid);
                chk($sformatf("rnd%0d rdata", cyc), rr_io.resp_data, e_rd);
            end
            chk($sformatf("rnd%0d free", cyc), rr_io.mshr_free, NMSHR - q.size());

            n_rv = '0; n_rid = '0; n_rd = '0;
            hit = -1;
            if (tg != 4'd0) foreach (q[j]) if (q[j].tag == tg) hit = j;
            if (hit >= 0) begin
                if (!q[hit].sq && !exc) begin
                    n_rv  = 3'(1 << q[hit].ch);
                    n_rid = q[hit].id;
                    n_rd  = tdat;
                end
                q.delete(hit);
            end
            if (exc) foreach (q[j]) q[j].sq = 1'b1;
            if (acc && !m_ist) q.push_back('{rsp, m_iid, m_ich, exc});
            if (acc || (m_iv && !m_ist && exc)) m_iv = 0;
            if (win >= 0) begin
                m_iv   = 1;
                m_ist  = st[win];
                m_ia   = a[win];
                m_isz  = sz[win];
                m_idat = d[win];
                m_iid  = id[win];
                m_ich  = win;
                m_rr   = (win + 1) % NCH;
            end
            e_rv = n_rv; e_rid = n_rid; e_rd = n_rd;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
